// File: rtl/oflow_event_mailbox.sv
// oflow_event_mailbox: per-core receiver for overflow/underflow events, with an event FIFO,
// a per-task pending bitmap, an overflow counter and a CSR slave for the local core.
module oflow_event_mailbox #(
    parameter int KEY_WIDTH = 4,
    parameter int DEPTH     = 8,
    parameter int CORE_ID   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        oflow_write,
    input  logic [31:0] oflow_address,
    input  logic [31:0] oflow_writedata,
    output logic        oflow_waitrequest,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [1:0]  cpu_address,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_irq
);
    localparam int EW = 2*KEY_WIDTH+1;
    localparam int AW = $clog2(DEPTH);
    localparam int NP = 1 << KEY_WIDTH;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [EW-1:0]        mem [DEPTH];
    logic [AW-1:0]        wp, rp;
    logic [AW:0]          cnt;
    logic [15:0]          ovf;
    logic [NP-1:0]        pending;
    logic                 irq_en;
    logic                 full, empty, kind, push, pop, flush, clr, ctrl_wr;
    logic [KEY_WIDTH-1:0] tid;
    logic [31:0]          rdata;

    assign full              = cnt == FULL;
    assign empty             = cnt == '0;
    assign oflow_waitrequest = full;
    assign kind              = oflow_writedata[2*KEY_WIDTH];
    assign tid               = oflow_writedata[KEY_WIDTH-1:0];
    // Events for other cores are still accepted, just not recorded
    assign push    = oflow_write && !full && oflow_address[20 +: KEY_WIDTH] == KEY_WIDTH'(CORE_ID);
    assign pop     = cpu_read && cpu_address == 2'd1 && !empty;
    assign ctrl_wr = cpu_write && cpu_address == 2'd3;
    assign flush   = ctrl_wr && cpu_writedata[1];
    assign clr     = ctrl_wr && cpu_writedata[2];

    always_comb begin
        rdata = cpu_address == 2'd0 ? {ovf, 8'(cnt), 6'b0, full, empty} :
                cpu_address == 2'd1 ? (empty ? 32'b0 : {1'b1, (31-EW)'(0), mem[rp]}) :
                cpu_address == 2'd2 ? 32'(pending) : {31'b0, irq_en};
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= oflow_writedata[EW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp           <= '0;
            rp           <= '0;
            cnt          <= '0;
            ovf          <= '0;
            pending      <= '0;
            irq_en       <= 1'b0;
            cpu_irq      <= 1'b0;
            cpu_readdata <= '0;
        end else begin
            if (flush) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                wp  <= wp + AW'(push);
                rp  <= rp + AW'(pop);
                cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            end
            if (clr) ovf <= '0;
            else if (push && kind && ovf != 16'hFFFF) ovf <= ovf + 16'd1;
            if (push) pending[tid] <= kind;
            if (ctrl_wr) irq_en <= cpu_writedata[0];
            cpu_irq <= irq_en && !empty;
            if (cpu_read) cpu_readdata <= rdata;
        end
    end
endmodule

// File: tb/tb_oflow_event_mailbox.sv
// tb_oflow_event_mailbox: directed vector table plus hand sequences for oflow_event_mailbox.
module tb_oflow_event_mailbox;
    logic        clk = 0, reset = 1;
    logic        oflow_write = 0, cpu_read = 0, cpu_write = 0;
    logic [31:0] oflow_address = 0, oflow_writedata = 0, cpu_writedata = 0;
    logic [1:0]  cpu_address = 0;
    logic        oflow_waitrequest, cpu_irq;
    logic [31:0] cpu_readdata;
    int n_chk = 0, n_fail = 0;

    oflow_event_mailbox #(.KEY_WIDTH(4), .DEPTH(8), .CORE_ID(0)) dut (
        .clk(clk), .reset(reset),
        .oflow_write(oflow_write), .oflow_address(oflow_address),
        .oflow_writedata(oflow_writedata), .oflow_waitrequest(oflow_waitrequest),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata), .cpu_irq(cpu_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        string       nm;
    } vec_t;
    vec_t tbl[$];

    localparam logic [1:0] EV = 0, RD = 1, WR = 2, IDLE = 3;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic ow, input logic [31:0] oa, input logic [31:0] od,
                       input logic cr, input logic cw, input logic [1:0] ca, input logic [31:0] cd);
        @(negedge clk);
        oflow_write = ow; oflow_address = oa; oflow_writedata = od;
        cpu_read = cr; cpu_write = cw; cpu_address = ca; cpu_writedata = cd;
        @(posedge clk);
        #1;
        oflow_write = 0; cpu_read = 0; cpu_write = 0;
    endtask

    initial begin
        tbl.push_back('{IDLE, 0, 0, 0, "irq_reset"});
        tbl.push_back('{RD, 0, 0, 32'h0000_0001, "status_reset"});
        tbl.push_back('{WR, 3, 1, 0, "ctrl_en"});
        tbl.push_back('{EV, 0, 32'h103, 0, "wait_ev1"});
        tbl.push_back('{RD, 0, 0, 32'h0001_0100, "status_ev1"});
        tbl.push_back('{RD, 2, 0, 32'h0000_0008, "pending_ev1"});
        tbl.push_back('{IDLE, 0, 0, 1, "irq_on"});
        tbl.push_back('{RD, 1, 0, 32'h8000_0103, "event_ev1"});
        tbl.push_back('{IDLE, 0, 0, 0, "irq_off"});
        tbl.push_back('{RD, 1, 0, 32'h0000_0000, "event_empty"});
        tbl.push_back('{RD, 0, 0, 32'h0001_0001, "status_empty"});
        tbl.push_back('{EV, 0, 32'h125, 0, "wait_ovf5"});
        tbl.push_back('{RD, 2, 0, 32'h0000_0028, "pending_set5"});
        tbl.push_back('{EV, 0, 32'h035, 0, "wait_unf5"});
        tbl.push_back('{RD, 2, 0, 32'h0000_0008, "pending_clr5"});
        tbl.push_back('{RD, 0, 0, 32'h0002_0200, "status_5"});
        tbl.push_back('{RD, 1, 0, 32'h8000_0125, "event_ovf5"});
        tbl.push_back('{RD, 1, 0, 32'h8000_0035, "event_unf5"});
        tbl.push_back('{EV, 32'h0010_0000, 32'h1FF, 0, "wait_other"});
        tbl.push_back('{RD, 2, 0, 32'h0000_0008, "pending_other"});
        tbl.push_back('{RD, 0, 0, 32'h0002_0001, "status_other"});
        tbl.push_back('{WR, 3, 5, 0, "ctrl_clr"});
        tbl.push_back('{RD, 0, 0, 32'h0000_0001, "status_clr"});
        tbl.push_back('{RD, 3, 0, 32'h0000_0001, "ctrl_read"});

        repeat (2) @(negedge clk);
        reset = 0;
        @(posedge clk);
        #1;
        chk("wait_reset", 32'(oflow_waitrequest), 0);
        chk("rdata_reset", cpu_readdata, 0);

        foreach (tbl[i]) begin
            case (tbl[i].op)
                EV: begin
                    chk(tbl[i].nm, 32'(oflow_waitrequest), tbl[i].exp);
                    cyc(1, tbl[i].a, tbl[i].d, 0, 0, 0, 0);
                end
                RD: begin
                    cyc(0, 0, 0, 1, 0, tbl[i].a[1:0], 0);
                    chk(tbl[i].nm, cpu_readdata, tbl[i].exp);
                end
                WR: cyc(0, 0, 0, 0, 1, tbl[i].a[1:0], tbl[i].d);
                default: begin
                    cyc(0, 0, 0, 0, 0, 0, 0);
                    chk(tbl[i].nm, 32'(cpu_irq), tbl[i].exp);
                end
            endcase
        end

        // Fill to full, hold the 9th write across a pop, then drain in order
        for (int i = 0; i < 8; i++) begin
            chk("wait_fill", 32'(oflow_waitrequest), 0);
            cyc(1, 0, 32'h10 | 32'(i), 0, 0, 0, 0);
        end
        chk("wait_full", 32'(oflow_waitrequest), 1);
        cyc(1, 0, 32'h18, 1, 0, 1, 0);
        chk("event_full_pop", cpu_readdata, 32'h8000_0010);
        chk("wait_drop", 32'(oflow_waitrequest), 0);
        cyc(1, 0, 32'h18, 0, 0, 0, 0);
        chk("wait_refull", 32'(oflow_waitrequest), 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("status_full", cpu_readdata, 32'h0000_0802);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 0, 1, 0);
            chk("event_order", cpu_readdata, 32'h8000_0011 + 32'(i));
        end

        // Flush beats a same-cycle push; pending and ovf_count still update
        cyc(1, 0, 32'h107, 0, 1, 3, 32'h3);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("status_flush", cpu_readdata, 32'h0001_0001);
        cyc(0, 0, 0, 1, 0, 2, 0);
        chk("pending_flush", cpu_readdata, 32'h0000_0080);

        // Counter clear with a same-cycle overflow leaves 0
        cyc(1, 0, 32'h101, 0, 1, 3, 32'h5);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("status_clr_ovf", cpu_readdata, 32'h0000_0100);

        // Push and pop together keep the fill level
        cyc(1, 0, 32'h102, 1, 0, 1, 0);
        chk("event_pushpop", cpu_readdata, 32'h8000_0101);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("status_pushpop", cpu_readdata, 32'h0001_0100);
        cyc(0, 0, 0, 1, 0, 1, 0);
        chk("event_after_pp", cpu_readdata, 32'h8000_0102);
        cyc(0, 0, 0, 1, 0, 2, 0);
        chk("pending_pp", cpu_readdata, 32'h0000_0086);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("irq_drain", 32'(cpu_irq), 0);

        // Asynchronous reset in the middle of a held write
        cyc(1, 0, 32'h10E, 0, 0, 0, 0);
        chk("irq_pre_reset", 32'(cpu_irq), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk("irq_pre_reset2", 32'(cpu_irq), 1);
        @(negedge clk);
        oflow_write = 1; oflow_writedata = 32'h10F;
        #2 reset = 1;
        #1;
        chk("wait_async", 32'(oflow_waitrequest), 0);
        chk("rdata_async", cpu_readdata, 0);
        chk("irq_async", 32'(cpu_irq), 0);
        @(negedge clk);
        reset = 0; oflow_write = 0;
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("status_post_rst", cpu_readdata, 32'h0000_0001);
        cyc(0, 0, 0, 1, 0, 2, 0);
        chk("pending_post_rst", cpu_readdata, 0);
        cyc(0, 0, 0, 1, 0, 3, 0);
        chk("ctrl_post_rst", cpu_readdata, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
